ready_instruction_queue: RTL
============================

// Module: ready_instruction_queue
// PURPOSE
//  Circular buffer between instruction fetch/decode and the 8-slot scheduler. Accepts one decoded
//  instruction per cycle from fetch, presents the oldest three to the scheduler with a 0..3 ready count
//  (current and next-cycle preview), and retires exactly the number the scheduler reports consumed.
//  Flushes all contents on a taken jump.
// PARAMETERS
//  INSTR_WIDTH  16  width of one decoded instruction word
//  DEPTH        8   queue entries; power of two, >=4
// PORTS
//  main_clk                     in   1            single clock, all state on posedge
//  main_reset_n                 in   1            synchronous active-low reset
//  fetch_instruction            in   INSTR_WIDTH  instruction offered by fetch
//  fetch_valid                  in   1            fetch_instruction is valid this cycle
//  fetch_ready                  out  1            queue accepts a push this cycle
//  jump_flush                   in   1            taken jump: discard all entries at this edge
//  used_ready_instruction_count in   2            entries consumed by scheduler at this edge (0..3)
//  ready_instruction_count_now  out  2            min(occupancy,3), registered
//  ready_instruction_count_next out  2            value ready_instruction_count_now takes after this edge
//  ready_instruction_0          out  INSTR_WIDTH  oldest entry (head)
//  ready_instruction_1          out  INSTR_WIDTH  head+1
//  ready_instruction_2          out  INSTR_WIDTH  head+2
//  occupancy                    out  clog2(DEPTH+1)  entries held, registered
// BEHAVIOUR
//  - Reset (main_reset_n==0 at edge): head=tail=0, occupancy=0, count_now=0; fetch_ready=0 while
//    main_reset_n low; storage contents not reset. Reset overrides flush, push and pop.
//  - push = fetch_valid & fetch_ready; fetch_ready = (occupancy < DEPTH) & main_reset_n. No
//    combinational path from used_ready_instruction_count to fetch_ready: a full queue refuses a push even
//    when a pop occurs the same cycle.
//  - pop = used_ready_instruction_count. Required: pop <= ready_instruction_count_now (simulation
//    assertion, message names both values). head advances by pop, mod DEPTH.
//  - Push writes storage[tail], tail advances by 1 mod DEPTH. Push and pop in the same cycle are both
//    applied: occupancy_next = occupancy + push - pop.
//  - jump_flush at edge: head=tail=0, occupancy=0; simultaneous push and pop ignored. Scheduler reports
//    pop=0 during a jump; a nonzero pop with jump_flush is legal and ignored.
//  - ready_instruction_count_next = min(occupancy_next,3), combinational from inputs, with flush→0 and
//    reset-low→0. ready_instruction_count_now <= ready_instruction_count_next every edge. Invariant:
//    count_now == min(occupancy,3).
//  - ready_instruction_k = storage[(head+k) mod DEPTH], driven from registered state only; the value is
//    meaningful only for k < ready_instruction_count_now (undefined otherwise; benches must not check).
//  - Latency: a pushed instruction is visible at ready_instruction_0..2 and counted in count_now on the
//    cycle after the push edge. Pushing into an empty queue gives a 1-cycle bypass-free latency.
//  - Wrap-around: pointer arithmetic is on clog2(DEPTH) bits with natural overflow. Ordering is preserved
//    across the wrap.
//  - Critical path: count_next feeds the scheduler's next-cycle slot assignment. Compute it from
//    occupancy, push, pop and flush only, never from storage.
// TESTING
//  1 Reset then push A,B,C,D on consecutive cycles, pop=0 -> count_now 0,1,2,3,3;
//    ready_0..2=A,B,C; occupancy=4.
//  2 Fill to DEPTH=8 with fetch_valid held high -> fetch_ready=0 when occupancy=8.
//    Same cycle pop=2 -> no push; occupancy 6; fetch_ready=1 on the next cycle.
//  3 Occupancy 3, push E and pop=3 in the same cycle -> occupancy=1; count_next=1 that cycle;
//    ready_0=E next cycle.
//  4 Wrap: push/pop continuously for 20 cycles with pop=1 each cycle -> FIFO order identical to push
//    order across the index 7->0 wrap.
//  5 Occupancy 5, jump_flush=1 with push and pop=2 -> occupancy=0, count_now=0 and count_next=0 that
//    cycle; the pushed entry never appears.
//  6 Reset asserted mid-stream at occupancy 4, with push -> occupancy=0, fetch_ready=0 during reset;
//    after release, the first push reappears at ready_0 one cycle later.

Source files
------------

// File: rtl/ready_instruction_queue.sv
// Ready-instruction circular buffer between fetch/decode and the scheduler.
// Presents the three oldest entries plus current and next-cycle ready counts.
module ready_instruction_queue #(
   parameter int INSTR_WIDTH = 16,
   parameter int DEPTH       = 8
) (
   input  logic                         main_clk,
   input  logic                         main_reset_n,
   input  logic [INSTR_WIDTH-1:0]       fetch_instruction,
   input  logic                         fetch_valid,
   output logic                         fetch_ready,
   input  logic                         jump_flush,
   input  logic [1:0]                   used_ready_instruction_count,
   output logic [1:0]                   ready_instruction_count_now,
   output logic [1:0]                   ready_instruction_count_next,
   output logic [INSTR_WIDTH-1:0]       ready_instruction_0,
   output logic [INSTR_WIDTH-1:0]       ready_instruction_1,
   output logic [INSTR_WIDTH-1:0]       ready_instruction_2,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
   localparam int PW = $clog2(DEPTH);
   localparam int OW = $clog2(DEPTH+1);

   logic [INSTR_WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]          head_q, head_d;
   logic [PW-1:0]          tail_q, tail_d;
   logic [OW-1:0]          occ_q, occ_d;
   logic [1:0]             cnt_q, cnt_d;
   logic                   push_s;
   logic                   write_s;

   // Readiness depends on registered occupancy only, never on this cycle's pop.
   assign fetch_ready = (occ_q < OW'(DEPTH)) & main_reset_n;
   assign push_s      = fetch_valid & fetch_ready;
   assign write_s     = push_s & ~jump_flush;

   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      occ_d  = occ_q;
      if (!main_reset_n || jump_flush) begin
         head_d = '0;
         tail_d = '0;
         occ_d  = '0;
      end else begin
         head_d = head_q + PW'(used_ready_instruction_count);
         tail_d = tail_q + PW'(push_s);
         occ_d  = occ_q + OW'(push_s) - OW'(used_ready_instruction_count);
      end
   end

   // Preview count comes from occupancy arithmetic only, keeping storage off this path.
   always_comb begin
      if (occ_d >= OW'(3)) begin
         cnt_d = 2'd3;
      end else begin
         cnt_d = occ_d[1:0];
      end
   end

   always_ff @(posedge main_clk) begin
      if (!main_reset_n) begin
         head_q <= '0;
         tail_q <= '0;
         occ_q  <= '0;
         cnt_q  <= 2'd0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         occ_q  <= occ_d;
         cnt_q  <= cnt_d;
      end
   end

   always_ff @(posedge main_clk) begin
      if (main_reset_n && write_s) begin
         mem_q[tail_q] <= fetch_instruction;
      end
   end

   assign ready_instruction_count_next = cnt_d;
   assign ready_instruction_count_now  = cnt_q;
   assign occupancy                    = occ_q;
   assign ready_instruction_0          = mem_q[head_q];
   assign ready_instruction_1          = mem_q[head_q + PW'(1)];
   assign ready_instruction_2          = mem_q[head_q + PW'(2)];

   ready_instruction_queue_chk u_chk (
      .clk      (main_clk),
      .rst_n    (main_reset_n),
      .flush    (jump_flush),
      .pop      (used_ready_instruction_count),
      .cnt_now  (cnt_q)
   );
endmodule

// Protocol checker: the scheduler may not consume more than is ready.
module ready_instruction_queue_chk (
   input logic       clk,
   input logic       rst_n,
   input logic       flush,
   input logic [1:0] pop,
   input logic [1:0] cnt_now
);
   always @(posedge clk) begin
      if (rst_n && !flush) begin
         assert (pop <= cnt_now)
            else $error("used_ready_instruction_count=%0d exceeds ready_instruction_count_now=%0d",
                        pop, cnt_now);
      end
   end
endmodule
